// File: rtl/cam_capture_ctrl_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cam_capture_ctrl_if : capture command handshake (register block -> sequencer)
// Rev 1.0
// ----------------------------------------------------------------------------
interface cam_capture_ctrl_if #(
  parameter int FC_WIDTH = 8
);
  logic                cmd_vld;
  logic                cmd_rdy;
  logic [1:0]          cmd_op;
  logic [FC_WIDTH-1:0] cmd_num;

  modport master (output cmd_vld, output cmd_op, output cmd_num, input cmd_rdy);
  modport slave  (input cmd_vld, input cmd_op, input cmd_num, output cmd_rdy);
endinterface
`default_nettype wire

// File: rtl/cam_capture_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cam_capture_ctrl : camera frame-capture sequencer (cam_clk domain)
// Rev 1.0
// ----------------------------------------------------------------------------
module cam_capture_ctrl #(
  parameter int FL_WIDTH = 23,
  parameter int FC_WIDTH = 8,
  parameter int TO_WIDTH = 24
) (
  input  wire logic                cam_clk,
  input  wire logic                cam_rst,
  cam_capture_ctrl_if.slave        cmd,
  input  wire logic [FL_WIDTH-1:0] frm_len_exp,
  input  wire logic [TO_WIDTH-1:0] timeout_cyc,
  input  wire logic                cam_vsync,
  input  wire logic                cam_vld,
  input  wire logic                cam_sof,
  input  wire logic                cam_eof,
  input  wire logic                err_clr,
  output logic                     en_cam,
  output logic                     busy,
  output logic                     frm_done,
  output logic [FC_WIDTH-1:0]      frm_cnt,
  output logic                     err_short,
  output logic                     err_long,
  output logic                     err_timeout
);

  localparam logic [1:0] c_OP_STOP   = 2'b00;
  localparam logic [1:0] c_OP_SINGLE = 2'b01;
  localparam logic [1:0] c_OP_BURST  = 2'b10;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ARM = 2'd1, S_CAPT = 2'd2, S_WAIT_VS = 2'd3} state_t;

  state_t                r_state, w_state_nxt;
  logic                  r_vs_d1, r_en_cam, r_cont, r_done;
  logic                  r_err_short, r_err_long, r_err_to;
  logic [FC_WIDTH-1:0]   r_rem, r_frm_cnt;
  logic [FL_WIDTH-1:0]   r_bcnt;
  logic [TO_WIDTH-1:0]   r_to_cnt;

  logic                  w_vs_re, w_cmd_rdy, w_start, w_stop, w_cont_eff, w_last;
  logic                  w_en_nxt, w_cont_nxt, w_done_nxt;
  logic                  w_set_short, w_set_long, w_set_to;
  logic [FC_WIDTH-1:0]   w_rem_eff, w_rem_nxt, w_fcnt_nxt;
  logic [FL_WIDTH-1:0]   w_bcnt_inc, w_bcnt_nxt;
  logic [TO_WIDTH-1:0]   w_to_nxt;

  assign w_vs_re   = cam_vsync & ~r_vs_d1;
  assign w_cmd_rdy = (r_state == S_IDLE) | (cmd.cmd_op == c_OP_STOP);
  assign w_start   = cmd.cmd_vld & (r_state == S_IDLE) & (cmd.cmd_op != c_OP_STOP);
  assign w_stop    = cmd.cmd_vld & (r_state != S_IDLE) & (cmd.cmd_op == c_OP_STOP);
  assign cmd.cmd_rdy = w_cmd_rdy;

  always_ff @(posedge cam_clk or posedge cam_rst) begin
    if (cam_rst) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    // A STOP during capture turns the current frame into the last one.
    w_cont_eff  = r_cont & ~w_stop;
    w_rem_eff   = (w_stop && r_state == S_CAPT) ? FC_WIDTH'(1) : r_rem;
    w_last      = !w_cont_eff && (w_rem_eff == FC_WIDTH'(1));
    w_bcnt_inc  = (cam_sof ? '0 : r_bcnt) + FL_WIDTH'(cam_vld);
    w_state_nxt = r_state;
    w_en_nxt    = r_en_cam;
    w_rem_nxt   = w_rem_eff;
    w_cont_nxt  = w_cont_eff;
    w_bcnt_nxt  = r_bcnt;
    w_fcnt_nxt  = r_frm_cnt;
    w_done_nxt  = 1'b0;
    w_set_short = 1'b0;
    w_set_long  = 1'b0;
    w_set_to    = 1'b0;
    w_to_nxt    = '0;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_state_nxt = S_ARM;
          w_en_nxt    = 1'b1;
          w_fcnt_nxt  = '0;
          w_cont_nxt  = (cmd.cmd_op != c_OP_SINGLE) && (cmd.cmd_op != c_OP_BURST);
          if (cmd.cmd_op == c_OP_SINGLE)     w_rem_nxt = FC_WIDTH'(1);
          else if (cmd.cmd_op == c_OP_BURST) w_rem_nxt = (cmd.cmd_num == '0) ? FC_WIDTH'(1) : cmd.cmd_num;
          else                               w_rem_nxt = '0;
        end
      end
      S_ARM: begin
        if (w_vs_re) begin
          w_state_nxt = S_CAPT;
          w_bcnt_nxt  = '0;
          w_en_nxt    = !w_last;
        end
      end
      S_CAPT: begin
        w_bcnt_nxt = w_bcnt_inc;
        if (cam_eof) begin
          w_done_nxt = 1'b1;
          w_fcnt_nxt = r_frm_cnt + FC_WIDTH'(1);
          if (!w_cont_eff) w_rem_nxt = w_rem_eff - FC_WIDTH'(1);
          if (w_bcnt_inc != frm_len_exp) w_set_long = 1'b1;
          if (!w_cont_eff && w_rem_nxt == '0) begin
            w_state_nxt = S_IDLE;
            w_en_nxt    = 1'b0;
          end else if (w_vs_re) begin
            // eof and the next VSYNC in one cycle: skip WAIT_VS entirely
            w_state_nxt = S_CAPT;
            w_bcnt_nxt  = '0;
            w_en_nxt    = w_cont_eff || (w_rem_nxt != FC_WIDTH'(1));
          end else begin
            w_state_nxt = S_WAIT_VS;
          end
        end else if (w_vs_re) begin
          w_set_short = 1'b1;
          w_bcnt_nxt  = '0;
          w_en_nxt    = !w_last;
        end
      end
      S_WAIT_VS: begin
        if (cam_vld) w_set_long = 1'b1;
        if (w_vs_re) begin
          w_state_nxt = S_CAPT;
          w_bcnt_nxt  = '0;
          w_en_nxt    = !w_last;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_stop) begin
      w_en_nxt = 1'b0;
      if (r_state != S_CAPT) w_state_nxt = S_IDLE;
    end
    if (r_state != S_IDLE && timeout_cyc != '0 && r_to_cnt == timeout_cyc) begin
      w_set_to    = 1'b1;
      w_en_nxt    = 1'b0;
      w_done_nxt  = 1'b0;
      w_fcnt_nxt  = r_frm_cnt;
      w_state_nxt = S_IDLE;
    end
    if (r_state != S_IDLE && w_state_nxt == r_state && !w_vs_re && !cam_vld)
      w_to_nxt = r_to_cnt + TO_WIDTH'(1);
  end

  always_ff @(posedge cam_clk or posedge cam_rst) begin
    if (cam_rst) begin
      r_vs_d1     <= 1'b0;
      r_en_cam    <= 1'b0;
      r_cont      <= 1'b0;
      r_done      <= 1'b0;
      r_rem       <= '0;
      r_frm_cnt   <= '0;
      r_bcnt      <= '0;
      r_to_cnt    <= '0;
      r_err_short <= 1'b0;
      r_err_long  <= 1'b0;
      r_err_to    <= 1'b0;
    end else begin
      r_vs_d1     <= cam_vsync;
      r_en_cam    <= w_en_nxt;
      r_cont      <= w_cont_nxt;
      r_done      <= w_done_nxt;
      r_rem       <= w_rem_nxt;
      r_frm_cnt   <= w_fcnt_nxt;
      r_bcnt      <= w_bcnt_nxt;
      r_to_cnt    <= w_to_nxt;
      r_err_short <= w_set_short | (r_err_short & ~err_clr);
      r_err_long  <= w_set_long  | (r_err_long  & ~err_clr);
      r_err_to    <= w_set_to    | (r_err_to    & ~err_clr);
    end
  end

  assign en_cam      = r_en_cam;
  assign busy        = (r_state != S_IDLE);
  assign frm_done    = r_done;
  assign frm_cnt     = r_frm_cnt;
  assign err_short   = r_err_short;
  assign err_long    = r_err_long;
  assign err_timeout = r_err_to;

endmodule
`default_nettype wire

// File: doc/cam_capture_ctrl.md
Name: cam_capture_ctrl

Overview:
- Sequences frame capture on the camera front end, in the cam_clk domain.
- Accepts single, burst and continuous capture commands. Drives the front end's en_cam so that enable lands before the correct VSYNC rising edge and is dropped before the last frame's successor.
- Tracks frame boundaries from the front end's sideband (cam_vld/cam_sof/cam_eof/vsync), counts completed frames, and flags short/long frames and stalls.
- Sits between the control register block (commands already synchronized to cam_clk) and the camera interface.

Parameters:
FL_WIDTH, 23, width of frame byte counter and expected-length input
FC_WIDTH, 8, width of frame counter and burst count
TO_WIDTH, 24, width of timeout counter

Ports:
cam_clk  in  1  camera pixel clock
cam_rst  in  1  asynchronous active-high reset
cmd_vld  in  1  command valid
cmd_rdy  out  1  command ready; accept = cmd_vld & cmd_rdy
cmd_op  in  2  00 STOP, 01 SINGLE, 10 BURST, 11 CONT
cmd_num  in  FC_WIDTH  frame count for BURST; 0 treated as 1
frm_len_exp  in  FL_WIDTH  expected bytes per frame, static while busy
timeout_cyc  in  TO_WIDTH  stall limit in cam_clk cycles; 0 disables
cam_vsync  in  1  registered VSYNC level, same stage as the front end's vsync_c1
cam_vld  in  1  front-end byte valid
cam_sof  in  1  front-end start of frame
cam_eof  in  1  front-end end of frame
err_clr  in  1  clears sticky errors
en_cam  out  1  capture enable to front end (registered)
busy  out  1  state != IDLE
frm_done  out  1  one-cycle pulse per completed frame
frm_cnt  out  FC_WIDTH  frames completed since last accepted start command; wraps
err_short  out  1  sticky: VSYNC rise before cam_eof
err_long  out  1  sticky: cam_vld after cam_eof within a frame, or eof byte count != frm_len_exp
err_timeout  out  1  sticky: stall limit reached

Behaviour:
- Reset: all outputs 0, state IDLE, internal counters 0.
- vs_re = cam_vsync & !vs_d1, where vs_d1 is registered internally. vs_re is cycle-aligned with the front end's vsync_re.
- cmd_rdy = (state==IDLE) | (cmd_op==STOP), combinational.
- Remaining-frame counter rem:
  - Loaded on an accepted start: SINGLE=1, BURST=max(cmd_num,1), CONT sets flag cont.
  - frm_cnt cleared on the same accept.
- States IDLE, ARM, CAPT, WAIT_VS.
- IDLE:
  - Accepted SINGLE/BURST/CONT -> ARM; en_cam<=1 next cycle.
  - STOP in IDLE is accepted with no effect.
- ARM (en_cam already high, ≥2 cycles before edge due to front-end sync):
  - vs_re -> CAPT; byte count cleared.
  - If !cont & rem==1, en_cam<=0 on that transition, so the front end latches 0 at the following VSYNC.
- CAPT:
  - byte count += cam_vld.
  - cam_eof:
    - frm_done=1 next cycle; frm_cnt+=1; rem-=1 unless cont.
    - If byte count incl. eof byte != frm_len_exp, set err_long.
    - If rem becomes 0 -> IDLE, else -> WAIT_VS.
  - vs_re before eof:
    - Set err_short; frame not counted; rem unchanged.
    - Stay in CAPT with byte count cleared (retry on the new frame).
    - en_cam re-evaluated by the ARM rule.
- WAIT_VS:
  - cam_vld sets err_long.
  - vs_re -> CAPT, byte count cleared, with the same en_cam drop rule for the last frame.
- STOP accepted while busy:
  - en_cam<=0 next cycle; cont cleared.
  - ARM or WAIT_VS -> IDLE immediately.
  - CAPT: rem forced to 1 so the current frame completes, then IDLE.
- Timeout:
  - Counter runs in ARM/CAPT/WAIT_VS; cleared on state entry, vs_re and cam_vld.
  - When count == timeout_cyc (≠0): set err_timeout, en_cam<=0, -> IDLE next cycle. No frm_done.
- Sticky errors: cleared by err_clr; a set in the same cycle as err_clr wins.
- Simultaneous cam_eof and vs_re in CAPT: eof processed first (frame counted). If the state goes to WAIT_VS, the same vs_re advances it directly to CAPT.
- Reset mid-capture: immediate return to reset values; en_cam drops asynchronously.

Test Plan:
- SINGLE, frm_len_exp=16, three VSYNC frames of 16 bytes each -> en_cam high from accept until first vs_re; one frm_done; frm_cnt=1; IDLE after eof; no errors.
- BURST cmd_num=3 -> 3 frm_done pulses on consecutive frames; en_cam drops on vs_re of frame 3; frm_cnt=3; cmd_num=0 -> exactly 1 frame.
- CONT, then STOP mid-frame 2 -> frame 2 completes (frm_cnt=2); en_cam low next cycle after STOP; IDLE after eof; no frame 3.
- Frame with vs_re after 10 bytes, no eof -> err_short=1; retry frame of 16 bytes counted; frm_cnt=1. Then err_clr -> err_short=0.
- cam_vld pulse in WAIT_VS, and eof at byte 15 with frm_len_exp=16 -> err_long=1 in both cases.
- timeout_cyc=100, ARM with no VSYNC -> err_timeout at cycle 100, en_cam=0, busy=0. timeout_cyc=0 -> waits indefinitely.
